ws2812b_frame_streamer: RTL and testbench

WS2812B_FRAME_STREAMER -- requirements
Module: ws2812b_frame_streamer

---
 rtl/ws2812b_pkg.sv | 20 ++
 rtl/ws2812b_frame_ram.sv | 48 ++++
 rtl/ws2812b_frame_streamer.sv | 149 ++++++++++++++
 tb/tb_ws2812b_frame_streamer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// Shared types for the WS2812B frame streamer: LED word width, FSM states and
// the colour record that lines up with the serialiser's {G,R,B} word.
package ws2812b_pkg;

    localparam int unsigned LED_BITS = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_NEXT
    } fsm_state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } led_rgb_t;

endpackage

// File: rtl/ws2812b_frame_ram.sv
// Double-banked LED colour store: writes go to the back bank, the registered
// read port serves the front bank selected by bank_sel.
module ws2812b_frame_ram
    import ws2812b_pkg::*;
#(
    parameter int unsigned DEPTH = 36,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             bank_sel,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[~bank_sel][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[bank_sel][rd_addr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812b_frame_streamer.sv
// Frame-paced LED streamer: on each fps tick walks the front bank and hands
// one brightness-scaled 24-bit GRB word at a time to the serialiser.
module ws2812b_frame_streamer
    import ws2812b_pkg::*;
#(
    parameter int unsigned LEDCOUNT   = 36,
    parameter int unsigned COLOR_BITS = 8,
    parameter int unsigned FPS_DIV    = 90000,
    localparam int unsigned AW = (LEDCOUNT > 1) ? $clog2(LEDCOUNT) : 1,
    localparam int unsigned CW = $clog2(FPS_DIV)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [3*COLOR_BITS-1:0] wr_data,
    input  logic                    swap_req,
    input  logic [2:0]              brightness_shift,
    output logic                    bitstream_available,
    output logic [LED_BITS-1:0]     bitstream,
    input  logic                    bitstream_read,
    output logic                    frame_busy,
    output logic                    frame_done,
    output logic                    frame_overrun
);

    fsm_state_t             state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             shift_q, shift_d;
    logic                   sel_q, sel_d;
    logic                   pend_q, pend_d;
    logic                   busy_q, busy_d;
    logic                   avail_q, avail_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   ram_we;
    logic [3*COLOR_BITS-1:0] rd_data;
    led_rgb_t               pix;

    assign ram_we = wr_en && (32'(wr_addr) < LEDCOUNT);

    ws2812b_frame_ram #(
        .DEPTH (LEDCOUNT),
        .WIDTH (3*COLOR_BITS),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .resetn   (resetn),
        .bank_sel (sel_q),
        .wr_en    (ram_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (state_q == ST_FETCH),
        .rd_addr  (idx_q),
        .rd_data  (rd_data)
    );

    // MSB-justify a channel to 8 bits, then dim by a logical right shift.
    function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c, input logic [2:0] sh);
        logic [COLOR_BITS+7:0] w;
        w = {c, 8'h00};
        return w[COLOR_BITS+7:COLOR_BITS] >> sh;
    endfunction

    always_comb begin
        tick    = (cnt_q == '0);
        cnt_d   = tick ? CW'(FPS_DIV - 1) : cnt_q - 1'b1;
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        pend_d  = pend_q | swap_req;
        busy_d  = busy_q;
        avail_d = avail_q;
        done_d  = 1'b0;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                // A request arriving in the swap cycle itself waits for the next tick.
                if (tick) begin
                    sel_d   = sel_q ^ pend_q;
                    pend_d  = swap_req;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                shift_d = brightness_shift;
                avail_d = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bitstream_read) begin
                    avail_d = 1'b0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == AW'(LEDCOUNT - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= CW'(FPS_DIV - 1);
            shift_q <= '0;
            sel_q   <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            avail_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            avail_q <= avail_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        pix.g = expand(rd_data[3*COLOR_BITS-1 -: COLOR_BITS], shift_q);
        pix.r = expand(rd_data[2*COLOR_BITS-1 -: COLOR_BITS], shift_q);
        pix.b = expand(rd_data[COLOR_BITS-1 -: COLOR_BITS], shift_q);
    end

    assign bitstream           = pix;
    assign bitstream_available = avail_q;
    assign frame_busy          = busy_q;
    assign frame_done          = done_q;
    assign frame_overrun       = tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// Bench for the frame streamer: an event-scheduled frame model checked every
// cycle on a 5-LED instance, plus literal checks on a 1-bit-colour instance.
module tb_ws2812b_frame_streamer;

    localparam int LC  = 5;
    localparam int CB  = 8;
    localparam int FPS = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0, wr_en = 1'b0, swap_req = 1'b0, bitstream_read = 1'b0;
    logic [2:0]  wr_addr = '0, brightness_shift = '0;
    logic [23:0] wr_data = '0;
    logic        bitstream_available, frame_busy, frame_done, frame_overrun;
    logic [23:0] bitstream;

    logic        resetn1 = 1'b0, wr_en1 = 1'b0, swap_req1 = 1'b0, bitstream_read1 = 1'b0;
    logic [0:0]  wr_addr1 = '0;
    logic [2:0]  wr_data1 = '0, brightness_shift1 = '0;
    logic        bitstream_available1, frame_busy1, frame_done1, frame_overrun1;
    logic [23:0] bitstream1;

    ws2812b_frame_streamer #(.LEDCOUNT(LC), .COLOR_BITS(CB), .FPS_DIV(FPS)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .brightness_shift(brightness_shift),
        .bitstream_available(bitstream_available), .bitstream(bitstream),
        .bitstream_read(bitstream_read), .frame_busy(frame_busy),
        .frame_done(frame_done), .frame_overrun(frame_overrun)
    );

    ws2812b_frame_streamer #(.LEDCOUNT(2), .COLOR_BITS(1), .FPS_DIV(8)) dut1 (
        .clk(clk), .resetn(resetn1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .swap_req(swap_req1), .brightness_shift(brightness_shift1),
        .bitstream_available(bitstream_available1), .bitstream(bitstream1),
        .bitstream_read(bitstream_read1), .frame_busy(frame_busy1),
        .frame_done(frame_done1), .frame_overrun(frame_overrun1)
    );

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame = snapshot of the front bank at the accepted tick; words
    // appear 2 cycles after the tick and 3 cycles after each consume.
    int          cyc = 0, avail_at = 0, done_at = -1, busy_end = -1;
    bit          m_busy = 0, m_sel = 0, m_pend = 0;
    logic [2:0]  cur_shift = '0;
    logic [23:0] last_bits = '0;
    logic [23:0] bank [2][LC];
    logic [23:0] q [$];

    function automatic logic [23:0] exp_pix(input logic [23:0] raw, input logic [2:0] sh);
        int ch, v;
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            ch = int'(raw >> (k*CB)) & ((1 << CB) - 1);
            v  = (ch * (1 << (8 - CB))) >> sh;
            r  = r | (24'(v) << (8*k));
        end
        return r;
    endfunction

    initial forever begin
        int  c;
        bit  e_tick, e_av;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            cyc = 0; m_busy = 0; m_sel = 0; m_pend = 0; q.delete();
            done_at = -1; busy_end = -1; avail_at = 0; cur_shift = '0; last_bits = '0;
        end else begin
            c      = cyc;
            e_tick = (c % FPS) == FPS - 1;
            e_av   = m_busy && q.size() > 0 && c >= avail_at;
            if (m_busy && c == avail_at - 1) cur_shift = brightness_shift;
            if (e_av && bitstream_read) begin
                last_bits = exp_pix(q[0], cur_shift);
                void'(q.pop_front());
                if (q.size() == 0) begin
                    done_at  = c + 2;
                    busy_end = c + 2;
                end else begin
                    avail_at = c + 3;
                end
            end
            if (wr_en && int'(wr_addr) < LC) bank[!m_sel][int'(wr_addr)] = wr_data;
            if (e_tick && !m_busy) begin
                if (m_pend) m_sel = !m_sel;
                m_pend = swap_req;
                q.delete();
                for (int i = 0; i < LC; i++) q.push_back(bank[m_sel][i]);
                m_busy   = 1;
                avail_at = c + 2;
                busy_end = -1;
            end else begin
                m_pend = m_pend | swap_req;
            end
            if (m_busy && c + 1 == busy_end) m_busy = 0;
            cyc = c + 1;
        end
    end

    initial forever begin
        bit          e_av, e_over;
        logic [23:0] e_bits;
        @(negedge clk);
        e_av   = m_busy && q.size() > 0 && cyc >= avail_at;
        e_bits = e_av ? exp_pix(q[0], cur_shift) : last_bits;
        e_over = ((cyc % FPS) == FPS - 1) && m_busy && resetn;
        chk("available", 32'(bitstream_available), 32'(e_av));
        chk("bitstream", 32'(bitstream), 32'(e_bits));
        chk("busy", 32'(frame_busy), 32'(m_busy));
        chk("done", 32'(frame_done), 32'(cyc == done_at));
        chk("overrun", 32'(frame_overrun), 32'(e_over));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_av(input int which, input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            if ((which == 0 ? bitstream_available : bitstream_available1) == 1'b1) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_avail%0d: not asserted within %0d cycles", which, maxc);
        end
    endtask

    initial begin
        logic [23:0] d1 [LC];
        d1[0] = 24'h112233; d1[1] = 24'h445566; d1[2] = 24'h778899;
        d1[3] = 24'hAABBCC; d1[4] = 24'hDDEEFF;

        // 1-bit colour instance: expansion and dimming literals.
        repeat (2) @(posedge clk);
        #1 resetn1 = 1'b1;
        wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 3'b101; step();
        wr_addr1 = 1'b1; wr_data1 = 3'b010; step();
        wr_en1 = 1'b0; swap_req1 = 1'b1; step();
        swap_req1 = 1'b0;
        wait_av(1, 20);
        chk("cb1_led0", 32'(bitstream1), 32'h800080);
        bitstream_read1 = 1'b1; brightness_shift1 = 3'd2; step();
        bitstream_read1 = 1'b0;
        wait_av(1, 10);
        chk("cb1_led1_shift2", 32'(bitstream1), 32'h002000);
        bitstream_read1 = 1'b1; step();
        bitstream_read1 = 1'b0; step();
        chk("cb1_frame_done", 32'(frame_done1), 32'h1);
        wait_av(1, 10);
        chk("cb1_led0_shift2", 32'(bitstream1), 32'h200020);

        // Main instance: first frame with literal latency and values.
        resetn = 1'b1;
        for (int k = 0; k < LC; k++) begin
            wr_en = 1'b1; wr_addr = 3'(k); wr_data = d1[k]; step();
        end
        wr_en = 1'b0; swap_req = 1'b1; step();
        swap_req = 1'b0;
        wait_av(0, 30);
        chk("first_latency_cycle", 32'(cyc), 32'd21);
        chk("first_led0", 32'(bitstream), 32'h112233);
        for (int k = 0; k < LC; k++) begin
            if (k > 0) wait_av(0, 10);
            if (k == 1) chk("led1_shift4", 32'(bitstream), 32'h040506);
            wr_en = 1'b1; wr_addr = 3'(k); wr_data = 24'h102030 + 24'(k); step();
            wr_en = 1'b0; step(); step();
            bitstream_read = 1'b1;
            if (k == 0) brightness_shift = 3'd4;
            if (k == 1) brightness_shift = 3'd0;
            step();
            bitstream_read = 1'b0;
            if (k == LC - 1) begin
                step();
                chk("frame_done_after_last", 32'(frame_done), 32'h1);
            end
        end

        // Stall the serialiser for 50 cycles; the word must hold.
        wait_av(0, 20);
        chk("hold_start", 32'(bitstream), 32'h112233);
        brightness_shift = 3'd7;
        repeat (50) step();
        chk("hold_available", 32'(bitstream_available), 32'h1);
        chk("hold_value", 32'(bitstream), 32'h112233);
        brightness_shift = 3'd0;
        bitstream_read = 1'b1; step();
        bitstream_read = 1'b0;
        wait_av(0, 10);
        chk("after_hold_led1", 32'(bitstream), 32'h445566);
        bitstream_read = 1'b1; step();
        bitstream_read = 1'b0;

        // Asynchronous reset mid-frame.
        #2 resetn = 1'b0;
        #1;
        chk("rst_available", 32'(bitstream_available), 32'h0);
        chk("rst_bitstream", 32'(bitstream), 32'h0);
        chk("rst_busy", 32'(frame_busy), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_overrun", 32'(frame_overrun), 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        wait_av(0, 30);
        chk("post_reset_latency", 32'(cyc), 32'd21);
        chk("post_reset_led0", 32'(bitstream), 32'h102030);

        // Randomised traffic with varying serialiser speed.
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 24'($urandom);
            swap_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) brightness_shift = 3'($urandom_range(0, 7));
            case ((i / 500) % 3)
                0:       bitstream_read = ($urandom_range(0, 1) == 1);
                1:       bitstream_read = ($urandom_range(0, 7) == 0);
                default: bitstream_read = 1'b1;
            endcase
            step();
        end
        wr_en = 1'b0; swap_req = 1'b0; bitstream_read = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
